// File: rtl/ycr1_mprf_arb_pkg.sv
// Shared types for the MPRF EXU/debug port arbiter: FSM states and the latched debug request.
package ycr1_mprf_arb_pkg;

    localparam int unsigned YCR1_MPRF_XLEN   = 32;
    localparam int unsigned YCR1_MPRF_AWIDTH = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        RD_WAIT = 2'd2,
        ACK     = 2'd3
    } type_ycr1_mprf_arb_fsm_e;

    typedef struct packed {
        logic                          we;
        logic [YCR1_MPRF_AWIDTH-1:0]   addr;
        logic [YCR1_MPRF_XLEN-1:0]     wdata;
    } type_ycr1_mprf_dbg_req_s;

endpackage

// File: rtl/ycr1_mprf_starve_cnt.sv
// Saturating starvation counter: clear has priority over increment, at_max_o flags saturation.
module ycr1_mprf_starve_cnt #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_max_o
);

    localparam int unsigned W = $clog2(MAX + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/ycr1_mprf_dbg_arb.sv
// EXU/debug arbiter for the MPRF rs1 read port and write port; EXU has priority, starvation forces a debug slot.
// Optional YCR1_MPRF_STAGE_EN: registered MPRF read data, read path goes through RD_WAIT.
module ycr1_mprf_dbg_arb
    import ycr1_mprf_arb_pkg::*;
#(
    parameter int unsigned XLEN       = YCR1_MPRF_XLEN,
    parameter int unsigned AWIDTH     = YCR1_MPRF_AWIDTH,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exu_rs_req_i,
    input  logic [AWIDTH-1:0] exu_rs1_addr_i,
    input  logic [AWIDTH-1:0] exu_rs2_addr_i,
    input  logic              exu_w_req_i,
    input  logic [AWIDTH-1:0] exu_rd_addr_i,
    input  logic [XLEN-1:0]   exu_rd_data_i,
    output logic              exu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [AWIDTH-1:0] dbg_addr_i,
    input  logic [XLEN-1:0]   dbg_wdata_i,
    output logic              dbg_ack_o,
    output logic [XLEN-1:0]   dbg_rdata_o,
    output logic              dbg_busy_o,
    output logic [AWIDTH-1:0] mprf_rs1_addr_o,
    output logic [AWIDTH-1:0] mprf_rs2_addr_o,
    output logic              mprf_w_req_o,
    output logic [AWIDTH-1:0] mprf_rd_addr_o,
    output logic [XLEN-1:0]   mprf_rd_data_o,
    input  logic [XLEN-1:0]   mprf_rs1_data_i
);

    type_ycr1_mprf_arb_fsm_e state_q, state_d;
    type_ycr1_mprf_dbg_req_s req_q, req_d;
    logic [XLEN-1:0]         rdata_q, rdata_d;
    logic                    cnt_clr, cnt_inc, cnt_at_max;
    logic                    port_free;

    ycr1_mprf_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (cnt_clr),
        .inc_i    (cnt_inc),
        .at_max_o (cnt_at_max)
    );

    assign port_free = req_q.we ? !exu_w_req_i : !exu_rs_req_i;

    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        rdata_d         = rdata_q;
        cnt_clr         = 1'b0;
        cnt_inc         = 1'b0;
        exu_stall_o     = 1'b0;
        dbg_ack_o       = 1'b0;
        mprf_rs1_addr_o = exu_rs1_addr_i;
        mprf_rs2_addr_o = exu_rs2_addr_i;
        mprf_w_req_o    = exu_w_req_i;
        mprf_rd_addr_o  = exu_rd_addr_i;
        mprf_rd_data_o  = exu_rd_data_i;

        unique case (state_q)
            IDLE: begin
                if (dbg_req_i) begin
                    req_d.we    = dbg_we_i;
                    req_d.addr  = dbg_addr_i;
                    req_d.wdata = dbg_wdata_i;
                    state_d     = PEND;
                end
            end
            PEND: begin
                if (port_free || cnt_at_max) begin
                    cnt_clr     = 1'b1;
                    exu_stall_o = !port_free;
                    if (req_q.we) begin
                        mprf_w_req_o   = 1'b1;
                        mprf_rd_addr_o = req_q.addr;
                        mprf_rd_data_o = req_q.wdata;
                        state_d        = ACK;
                    end else begin
                        mprf_rs1_addr_o = req_q.addr;
`ifdef YCR1_MPRF_STAGE_EN
                        state_d = RD_WAIT;
`else
                        rdata_d = mprf_rs1_data_i;
                        state_d = ACK;
`endif
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RD_WAIT: begin
                // rs1 port already back with the EXU; only the staged data is taken here
                rdata_d = mprf_rs1_data_i;
                state_d = ACK;
            end
            ACK: begin
                dbg_ack_o = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
        end
    end

    assign dbg_rdata_o = rdata_q;
    assign dbg_busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_ycr1_mprf_dbg_arb.sv
// Directed bench for ycr1_mprf_dbg_arb with a behavioural MPRF (honours YCR1_MPRF_STAGE_EN).
module tb_ycr1_mprf_dbg_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exu_rs_req, exu_w_req;
    logic [4:0]  exu_rs1_addr, exu_rs2_addr, exu_rd_addr;
    logic [31:0] exu_rd_data;
    logic        exu_stall;
    logic        dbg_req, dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack, dbg_busy;
    logic [31:0] dbg_rdata;
    logic [4:0]  mprf_rs1_addr, mprf_rs2_addr, mprf_rd_addr;
    logic        mprf_w_req;
    logic [31:0] mprf_rd_data, mprf_rs1_data;

    logic        mdl_clr;
    logic [31:0] regs [32];

    int n_cmp = 0;
    int n_err = 0;

`ifdef YCR1_MPRF_STAGE_EN
    localparam int ACK_RD = 3;
`else
    localparam int ACK_RD = 2;
`endif

    always #5 clk = ~clk;

    ycr1_mprf_dbg_arb #(
        .XLEN       (32),
        .AWIDTH     (5),
        .STARVE_MAX (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .exu_rs_req_i    (exu_rs_req),
        .exu_rs1_addr_i  (exu_rs1_addr),
        .exu_rs2_addr_i  (exu_rs2_addr),
        .exu_w_req_i     (exu_w_req),
        .exu_rd_addr_i   (exu_rd_addr),
        .exu_rd_data_i   (exu_rd_data),
        .exu_stall_o     (exu_stall),
        .dbg_req_i       (dbg_req),
        .dbg_we_i        (dbg_we),
        .dbg_addr_i      (dbg_addr),
        .dbg_wdata_i     (dbg_wdata),
        .dbg_ack_o       (dbg_ack),
        .dbg_rdata_o     (dbg_rdata),
        .dbg_busy_o      (dbg_busy),
        .mprf_rs1_addr_o (mprf_rs1_addr),
        .mprf_rs2_addr_o (mprf_rs2_addr),
        .mprf_w_req_o    (mprf_w_req),
        .mprf_rd_addr_o  (mprf_rd_addr),
        .mprf_rd_data_o  (mprf_rd_data),
        .mprf_rs1_data_i (mprf_rs1_data)
    );

    // Register file model: x0 never written, so it always reads 0
    always @(posedge clk) begin
        if (mdl_clr) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (mprf_w_req && (mprf_rd_addr != 5'd0)) begin
            regs[mprf_rd_addr] <= mprf_rd_data;
        end
    end

`ifdef YCR1_MPRF_STAGE_EN
    logic [31:0] rs1_q;
    always @(posedge clk) rs1_q <= regs[mprf_rs1_addr];
    assign mprf_rs1_data = rs1_q;
`else
    assign mprf_rs1_data = regs[mprf_rs1_addr];
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one debug access from cycle 0 and records per-cycle behaviour up to the ack
    task automatic dbg_run(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                           output int ack_cyc, output logic [31:0] stall_m,
                           output logic [31:0] wreq_m, output logic [31:0] pass_m);
        ack_cyc   = -1;
        stall_m   = '0;
        wreq_m    = '0;
        pass_m    = '0;
        dbg_req   = 1'b1;
        dbg_we    = we;
        dbg_addr  = addr;
        dbg_wdata = wdata;
        for (int c = 0; c < 20; c++) begin
            #1;
            stall_m[c] = exu_stall;
            wreq_m[c]  = mprf_w_req;
            pass_m[c]  = (mprf_rs1_addr === exu_rs1_addr);
            if (dbg_ack) begin
                ack_cyc = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        dbg_req = 1'b0;
        step();
    endtask

    task automatic test_reset();
        n_cmp++; if (dbg_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got=%b exp=0", dbg_ack); end
        n_cmp++; if (dbg_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", dbg_busy); end
        n_cmp++; if (dbg_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got=%h exp=0", dbg_rdata); end
        n_cmp++; if (exu_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", exu_stall); end
        n_cmp++; if ({mprf_w_req, mprf_rd_addr, mprf_rd_data, mprf_rs1_addr, mprf_rs2_addr} !== '0) begin
            n_err++; $display("FAIL reset_mprf got=%b/%h/%h/%h/%h exp=0", mprf_w_req, mprf_rd_addr,
                              mprf_rd_data, mprf_rs1_addr, mprf_rs2_addr);
        end
    endtask

    task automatic test_idle_read();
        int ack; logic [31:0] sm, wm, pm;
        exu_w_req = 1'b1; exu_rd_addr = 5'd5; exu_rd_data = 32'hDEADBEEF;
        step();
        exu_w_req = 1'b0; exu_rd_addr = '0; exu_rd_data = '0;
        dbg_run(1'b0, 5'd5, 32'h0, ack, sm, wm, pm);
        n_cmp++; if (ack !== ACK_RD) begin n_err++; $display("FAIL idle_rd_ack got=%0d exp=%0d", ack, ACK_RD); end
        n_cmp++; if (dbg_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL idle_rd_data got=%h exp=deadbeef", dbg_rdata); end
        n_cmp++; if (sm !== 32'h0) begin n_err++; $display("FAIL idle_rd_stall got=%h exp=0", sm); end
    endtask

    task automatic test_idle_write();
        int ack; logic [31:0] sm, wm, pm;
        dbg_run(1'b1, 5'd7, 32'h12345678, ack, sm, wm, pm);
        n_cmp++; if (ack !== 2) begin n_err++; $display("FAIL idle_wr_ack got=%0d exp=2", ack); end
        n_cmp++; if (wm !== 32'h2) begin n_err++; $display("FAIL idle_wr_wreq got=%h exp=00000002", wm); end
        n_cmp++; if (sm !== 32'h0) begin n_err++; $display("FAIL idle_wr_stall got=%h exp=0", sm); end
        exu_rs_req = 1'b1; exu_rs1_addr = 5'd7;
        step();
        n_cmp++; if (mprf_rs1_data !== 32'h12345678) begin n_err++; $display("FAIL idle_wr_readback got=%h exp=12345678", mprf_rs1_data); end
        exu_rs_req = 1'b0; exu_rs1_addr = '0;
    endtask

    task automatic test_starve();
        int ack; logic [31:0] sm, wm, pm, pexp;
        exu_rs_req = 1'b1; exu_rs1_addr = 5'd3;
        dbg_run(1'b0, 5'd5, 32'h0, ack, sm, wm, pm);
        exu_rs_req = 1'b0; exu_rs1_addr = '0;
        pexp = ((32'h1 << (ACK_RD + 5)) - 32'h1) & ~32'h20;
        n_cmp++; if (ack !== ACK_RD + 4) begin n_err++; $display("FAIL starve_ack got=%0d exp=%0d", ack, ACK_RD + 4); end
        n_cmp++; if (sm !== 32'h20) begin n_err++; $display("FAIL starve_stall got=%h exp=00000020", sm); end
        n_cmp++; if (pm !== pexp) begin n_err++; $display("FAIL starve_pass got=%h exp=%h", pm, pexp); end
        n_cmp++; if (dbg_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL starve_data got=%h exp=deadbeef", dbg_rdata); end
    endtask

    task automatic test_x0();
        int ack; logic [31:0] sm, wm, pm;
        dbg_run(1'b1, 5'd0, 32'hFFFFFFFF, ack, sm, wm, pm);
        n_cmp++; if (ack !== 2) begin n_err++; $display("FAIL x0_wr_ack got=%0d exp=2", ack); end
        dbg_run(1'b0, 5'd0, 32'h0, ack, sm, wm, pm);
        n_cmp++; if (ack !== ACK_RD) begin n_err++; $display("FAIL x0_rd_ack got=%0d exp=%0d", ack, ACK_RD); end
        n_cmp++; if (dbg_rdata !== 32'h0) begin n_err++; $display("FAIL x0_rd_data got=%h exp=0", dbg_rdata); end
    endtask

    task automatic test_reset_mid();
        int ack; int bad; logic [31:0] sm, wm, pm;
        exu_w_req = 1'b1; exu_rd_addr = 5'd3; exu_rd_data = 32'h0BAD0BAD;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd11; dbg_wdata = 32'h55AA55AA;
        step();
        dbg_req = 1'b0;
        step();
        n_cmp++; if (dbg_busy !== 1'b1) begin n_err++; $display("FAIL rstmid_pend got=%b exp=1", dbg_busy); end
        rst_n = 1'b0;
        exu_w_req = 1'b0; exu_rd_addr = '0; exu_rd_data = '0;
        dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        #1;
        n_cmp++; if ({dbg_ack, dbg_busy, exu_stall, mprf_w_req, mprf_rd_addr, mprf_rd_data} !== '0) begin
            n_err++; $display("FAIL rstmid_outs got=%b%b%b%b/%h/%h exp=0", dbg_ack, dbg_busy, exu_stall,
                              mprf_w_req, mprf_rd_addr, mprf_rd_data);
        end
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (dbg_ack || mprf_w_req || dbg_busy) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rstmid_quiet got=%0d exp=0", bad); end
        n_cmp++; if (regs[11] !== 32'h0) begin n_err++; $display("FAIL rstmid_nowrite got=%h exp=0", regs[11]); end
        rst_n = 1'b1;
        step();
        dbg_run(1'b0, 5'd5, 32'h0, ack, sm, wm, pm);
        n_cmp++; if (ack !== ACK_RD) begin n_err++; $display("FAIL rstmid_after_ack got=%0d exp=%0d", ack, ACK_RD); end
        n_cmp++; if (dbg_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rstmid_after_data got=%h exp=deadbeef", dbg_rdata); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ack_m, busy_m, exp_m;
        int nack;
        ack_m = '0; busy_m = '0; nack = 0;
        exp_m = (32'h1 << ACK_RD) | (32'h1 << (2 * ACK_RD + 1));
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
        for (int c = 0; c < 20; c++) begin
            #1;
            ack_m[c]  = dbg_ack;
            busy_m[c] = dbg_busy;
            if (dbg_ack) begin
                nack++;
                if (nack == 1) dbg_addr = 5'd7;
                else begin
                    n_cmp++; if (dbg_rdata !== 32'h12345678) begin n_err++; $display("FAIL b2b_data2 got=%h exp=12345678", dbg_rdata); end
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        dbg_req = 1'b0;
        step();
        n_cmp++; if (ack_m !== exp_m) begin n_err++; $display("FAIL b2b_acks got=%h exp=%h", ack_m, exp_m); end
        n_cmp++; if (busy_m[ACK_RD+1] !== 1'b0) begin n_err++; $display("FAIL b2b_idle_gap got=%b exp=0", busy_m[ACK_RD+1]); end
        n_cmp++; if (dbg_ack !== 1'b0) begin n_err++; $display("FAIL b2b_no_third got=%b exp=0", dbg_ack); end
    endtask

    initial begin
        rst_n = 1'b0; mdl_clr = 1'b1;
        exu_rs_req = 1'b0; exu_w_req = 1'b0;
        exu_rs1_addr = '0; exu_rs2_addr = '0; exu_rd_addr = '0; exu_rd_data = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1; mdl_clr = 1'b0;
        step();
        test_reset();
        test_idle_read();
        test_idle_write();
        test_starve();
        test_x0();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ycr1_mprf_dbg_arb.md
# ycr1_mprf_dbg_arb

Port arbiter between the EXU and the debug module for the multi-port register file (MPRF). It shares the MPRF rs1 read port and the single write port so the debug module can read or write GPRs while the hart runs. The EXU gets fixed priority; a starvation counter forces a debug slot by stalling the EXU for one cycle. The block sits between EXU/debug and `ycr1_pipe_mprf`, and passes EXU traffic through unchanged when debug is idle.

## Interface
- XLEN, 32, data width
- AWIDTH, 5, GPR address width
- STARVE_MAX, 4, maximum number of PEND cycles without a grant before a debug grant is forced (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- exu_rs_req_i  in  1  EXU uses the read ports this cycle
- exu_rs1_addr_i / exu_rs2_addr_i  in  AWIDTH  EXU read addresses
- exu_w_req_i  in  1  EXU write request
- exu_rd_addr_i  in  AWIDTH  EXU write address
- exu_rd_data_i  in  XLEN  EXU write data
- exu_stall_o  out  1  EXU must hold its current read/write request this cycle
- dbg_req_i  in  1  debug access request, held until dbg_ack_o
- dbg_we_i  in  1  1 = write, 0 = read
- dbg_addr_i  in  AWIDTH  GPR index
- dbg_wdata_i  in  XLEN  write data
- dbg_ack_o  out  1  one-cycle completion pulse
- dbg_rdata_o  out  XLEN  read data, valid with ack and held until the next accept
- dbg_busy_o  out  1  FSM not IDLE
- mprf_rs1_addr_o / mprf_rs2_addr_o  out  AWIDTH  to MPRF
- mprf_w_req_o / mprf_rd_addr_o / mprf_rd_data_o  out  1/AWIDTH/XLEN  to MPRF
- mprf_rs1_data_i  in  XLEN  MPRF rs1 read data

## Operation
- **Reset values:** all outputs are 0 after reset. State is IDLE, the starvation counter is 0, and the latched request and dbg_rdata are 0.
- **FSM states:** IDLE → PEND → (RD_WAIT) → ACK → IDLE.
- **IDLE:** when dbg_req_i=1, latch we/addr/wdata and go to PEND. Request inputs are ignored in every other state.
- **PEND, grant condition:**
  - read: grant when exu_rs_req_i=0;
  - write: grant when exu_w_req_i=0;
  - otherwise, grant when starve_cnt==STARVE_MAX; in that cycle exu_stall_o=1.
- **PEND, grant cycle:**
  - read: mprf_rs1_addr_o = latched addr;
  - write: mprf_w_req_o=1, mprf_rd_addr_o/mprf_rd_data_o = latched addr/data.
  - The EXU side of every other port passes through.
- **PEND, no grant:** starve_cnt increments, saturating at STARVE_MAX.
- **PEND, after grant:** starve_cnt clears. A read goes to RD_WAIT (staged builds) or to ACK with mprf_rs1_data_i captured. A write goes to ACK.
- **ACK:** dbg_ack_o=1 for one cycle, then IDLE. A new request is accepted no earlier than the cycle after ACK.
- **x0 access:** a write is issued unchanged; the MPRF discards it. A read returns 0 from the MPRF. Both are acked normally.
- **exu_stall_o:** only ever high in a forced-grant PEND cycle.
- **Reset mid-operation:** the FSM aborts to IDLE with no ack; no write is issued after rst_n falls.

## Timing
- Debug request visible in cycle 0 → PEND in cycle 1.
- Unstalled EXU:
  - read: grant in cycle 1, ack in cycle 2 (cycle 3 with YCR1_MPRF_STAGE_EN);
  - write: grant in cycle 1, ack in cycle 2; the MPRF is updated at the end of cycle 1.
- Worst case: grant in cycle 1+STARVE_MAX, ack latency grows by the same amount.
- A debug write and an EXU read of the same register in the same cycle are legal; the MPRF bypass resolves them.

## Configuration
- **YCR1_MPRF_STAGE_EN defined:** the MPRF read data is registered. The read path inserts RD_WAIT, and mprf_rs1_data_i is captured one cycle after the grant. In RD_WAIT the rs1 port returns to the EXU.
- **Undefined:** the read is combinational and data is captured at the end of the grant cycle.

## Structure
- Package `ycr1_mprf_arb_pkg` holds:
  - the FSM state enum `type_ycr1_mprf_arb_fsm_e` (IDLE, PEND, RD_WAIT, ACK);
  - a request struct `type_ycr1_mprf_dbg_req_s` (we, addr, wdata).
- One sub-module, `ycr1_mprf_starve_cnt`: a saturating counter with clear/increment inputs and an `at_max` output.
- Everything else is flat.

## Test plan
- **Idle EXU, read:** write x5=0xDEADBEEF via the EXU, then issue a debug read of x5 → ack in cycle 2 (3 staged), dbg_rdata=0xDEADBEEF, exu_stall_o never asserted.
- **Idle EXU, write:** debug write x7=0x12345678 → mprf_w_req_o high exactly in cycle 1, ack in cycle 2; a subsequent EXU read of x7 returns 0x12345678.
- **Busy EXU, starvation:** exu_rs_req_i held at 1, STARVE_MAX=4, debug read → exu_stall_o high only in cycle 5, ack in cycle 6 (7 staged), EXU rs1 passthrough in all other cycles.
- **x0:** debug write x0=0xFFFFFFFF, then debug read x0 → both acked, read returns 0.
- **Reset mid-operation:** assert rst_n low while in PEND with a write latched → no mprf_w_req_o, no ack, all outputs 0, FSM IDLE; a new request after reset completes normally.
- **Back-to-back:** dbg_req_i held high across ack → second access accepted in the cycle after ACK, no double ack.
